// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the 8-bit pipelined core.
//
// Owns the fetch PC (fpc), drives the combinational instruction ROM and
// buffers fetched {pc, inst} pairs in a small in-order circular queue that
// feeds the IF/ID pipeline register.
//
// Handshake: the head entry is offered while out_valid=1 and is consumed on
// a rising edge where out_valid=1, stall=0 and redirect=0. redirect flushes
// the queue and reloads fpc, and takes priority over stall.
//
// Optional feature, enabled by defining FETCH_BYPASS_EN: when the queue is
// empty the ROM word is presented straight on out_* in the same cycle, which
// removes one bubble cycle after a redirect.
//
// DEPTH must be a power of two and at least 2 (the pointers wrap naturally).
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 12,
  parameter int INST_W = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INST_W-1:0]        imem_data,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     stall,
  output logic                     out_valid,
  output logic [INST_W-1:0]        out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Fetch PC and queue bookkeeping.
  logic [PC_W-1:0]   fpc;
  logic [AW-1:0]     rp;
  logic [AW-1:0]     wp;
  logic [CW-1:0]     cnt;

  // Queue storage. Not reset: entries are only visible while cnt covers them.
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  // Control terms.
  logic q_valid;    // queue holds at least one entry
  logic byp_valid;  // empty queue presenting the live ROM word
  logic pop;        // head consumed by IF/ID this cycle
  logic push;       // fetch slot used this cycle (fpc advances)
  logic byp_take;   // live ROM word consumed without touching storage
  logic wr_en;      // ROM word written into storage
  logic rd_adv;     // stored head retired

  // Bypass qualification: only when empty, not redirecting and out of reset.
  always_comb begin
    q_valid = (cnt != '0);
`ifdef FETCH_BYPASS_EN
    byp_valid = reset & ~redirect & ~q_valid;
`else
    byp_valid = 1'b0;
`endif
  end

  // Handshake and queue control; redirect overrides both push and pop.
  always_comb begin
    out_valid = q_valid | byp_valid;
    pop       = out_valid & ~stall & ~redirect;
    push      = ~redirect & ((cnt < FULL) | pop);
    byp_take  = byp_valid & pop;
    wr_en     = push & ~byp_take;
    rd_adv    = pop & ~byp_take;
  end

  // Output mux: live ROM word on bypass, else stored head, else NOP / PC 0.
  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (byp_valid) begin
      out_inst = imem_data;
      out_pc   = fpc;
    end else if (q_valid) begin
      out_inst = inst_mem[rp];
      out_pc   = pc_mem[rp];
    end
  end

  // Status outputs.
  always_comb begin
    imem_addr = fpc;
    count     = cnt;
  end

  // Fetch PC, pointers and occupancy; redirect flushes and reloads fpc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc <= '0;
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (redirect) begin
      fpc <= redirect_pc;
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        fpc <= fpc + PC_W'(1);
      end
      if (wr_en) begin
        wp <= wp + AW'(1);
      end
      if (rd_adv) begin
        rp <= rp + AW'(1);
      end
      case ({wr_en, rd_adv})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write of the fetched {pc, inst} pair at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wp]   <= fpc;
      inst_mem[wp] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: bench for fetch_queue.
// Driver applies inputs just after each rising edge and records the outputs
// the reference model predicts for that cycle; a monitor on the falling edge
// pops and compares them, and pops a transfer queue for every handshake.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 12;
  localparam int INST_W = 19;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int XW     = PC_W + INST_W;

  logic              clk;
  logic              reset;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              stall;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [CW-1:0]     count;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .out_valid(out_valid),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model (injective, so every address is distinct) ----
  function automatic logic [INST_W-1:0] rom(input logic [PC_W-1:0] a);
    return {a[6:0], a} ^ 19'h2B5C3;
  endfunction

  assign imem_data = rom(imem_addr);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [CW-1:0]     cnt;
    logic [PC_W-1:0]   addr;
    logic              v;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } exp_t;

  exp_t              state_q[$];   // expected outputs, one per cycle
  logic [XW-1:0]     exp_q[$];     // expected handshake transfers
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of fetched {pc, inst} pairs plus the fetch PC, advanced once per cycle.
  logic [XW-1:0]   mq[$];
  logic [PC_W-1:0] m_fpc = '0;

  task automatic model_cycle();
    exp_t          e;
    logic          byp;
    logic          take;
    logic [XW-1:0] head;
    if (!reset) begin
      mq.delete();
      m_fpc = '0;
      e.cnt = '0; e.addr = '0; e.v = 1'b0; e.pc = '0; e.inst = '0;
      state_q.push_back(e);
      return;
    end
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (mq.size() == 0) && !redirect;
`endif
    head = '0;
    if (byp) head = {m_fpc, rom(m_fpc)};
    else if (mq.size() > 0) head = mq[0];
    e.cnt  = CW'(mq.size());
    e.addr = m_fpc;
    e.v    = byp || (mq.size() > 0);
    e.pc   = head[XW-1:INST_W];
    e.inst = head[INST_W-1:0];
    state_q.push_back(e);
    if (redirect) begin
      mq.delete();
      m_fpc = redirect_pc;
    end else begin
      take = e.v && !stall;
      if (take) exp_q.push_back(head);
      if (take && byp) begin
        m_fpc = m_fpc + 12'd1;
      end else begin
        if (take) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back({m_fpc, rom(m_fpc)});
          m_fpc = m_fpc + 12'd1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: apply inputs, predict, wait for next edge.
  task automatic step(input logic r_n, input logic s, input logic rd, input logic [PC_W-1:0] tgt);
    reset       = r_n;
    stall       = s;
    redirect    = rd;
    redirect_pc = tgt;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_step(input logic allow_reset);
    logic r_n;
    r_n = allow_reset ? ($urandom_range(0, 49) != 0) : 1'b1;
    step(r_n, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
         PC_W'($urandom_range(0, 4095)));
  endtask

  // ---------------- monitor ----------------
  exp_t          m_e;
  logic [XW-1:0] m_x;

  always @(negedge clk) begin
    if (state_q.size() > 0) begin
      m_e = state_q.pop_front();
      chk("mon_count", 32'(count), 32'(m_e.cnt));
      chk("mon_imem_addr", 32'(imem_addr), 32'(m_e.addr));
      chk("mon_out_valid", 32'(out_valid), 32'(m_e.v));
      chk("mon_out_pc", 32'(out_pc), 32'(m_e.pc));
      chk("mon_out_inst", 32'(out_inst), 32'(m_e.inst));
      if (reset && out_valid && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL xfer_underflow: got handshake pc %0h expected none", out_pc);
        end else begin
          m_x = exp_q.pop_front();
          chk("xfer_pc", 32'(out_pc), 32'(m_x[XW-1:INST_W]));
          chk("xfer_inst", 32'(out_inst), 32'(m_x[INST_W-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;

    // Reset held with random inputs.
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    PC_W'($urandom_range(0, 4095)));
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", 32'(out_inst), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Release under stall: first edge fetches address 0.
    step(1'b1, 1'b1, 1'b0, '0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", 32'(out_pc), 32'd0);
    chk("first_inst", 32'(out_inst), 32'(rom(12'h000)));
    repeat (5) step(1'b1, 1'b1, 1'b0, '0);
    chk("stall_count", 32'(count), 32'd4);
    chk("stall_addr", 32'(imem_addr), 32'd4);

    // Full queue, one unstalled cycle: pop and push together.
    step(1'b1, 1'b0, 1'b0, '0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr", 32'(imem_addr), 32'd5);
    chk("full_pc", 32'(out_pc), 32'd1);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);

    // Build count=3, then redirect to 0x100 (redirect wins over stall).
    step(1'b1, 1'b1, 1'b1, 12'h050);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    chk("pre_redir_count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 12'h100);
    chk("redir_count", 32'(count), 32'd0);
`ifndef FETCH_BYPASS_EN
    chk("redir_valid", 32'(out_valid), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCH_BYPASS_EN
    chk("redir_pc", 32'(out_pc), 32'h100);
    chk("redir_inst", 32'(out_inst), 32'(rom(12'h100)));
`endif

    // PC wrap-around.
    step(1'b1, 1'b0, 1'b1, 12'hFFE);
    step(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCH_BYPASS_EN
    chk("wrap_pc0", 32'(out_pc), 32'hFFE);
`endif
    step(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCH_BYPASS_EN
    chk("wrap_pc1", 32'(out_pc), 32'hFFF);
`endif
    step(1'b1, 1'b0, 1'b0, '0);
`ifndef FETCH_BYPASS_EN
    chk("wrap_pc2", 32'(out_pc), 32'h000);
`endif

    // Asynchronous reset mid-cycle with two entries queued.
    step(1'b1, 1'b0, 1'b1, 12'h200);
    repeat (2) step(1'b1, 1'b1, 1'b0, '0);
    chk("pre_arst_count", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);

    // Randomized traffic, first without resets, then with occasional resets.
    repeat (300) rand_step(1'b0);
    repeat (300) rand_step(1'b1);

    chk("xfer_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("state_queue_drained", 32'(state_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
